// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: FSM state encodings used by both
//                the transmitter and the receiver, and parity type constants.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    // Frame-level FSM states, common to the TX and RX paths
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // PAR_TYP encodings
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Expected parity bit given the XOR of all data bits and the parity type
    function automatic logic expected_parity(input logic data_xor, input logic par_typ);
        return data_xor ^ (par_typ != PAR_EVEN);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sampler.sv
// ============================================================================
//  Module      : uart_rx_sampler
//  Description : Per-bit edge counter and mid-bit sampler for the UART
//                receiver. Captures the line around the bit centre and
//                produces the bit decision plus bit-position strobes.
//                Macro UART_RX_MAJORITY_EN selects a 2-of-3 majority vote
//                over three centre samples; otherwise the single centre
//                sample is used. Decision timing is identical either way.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_sampler #(
    parameter int OVERSAMPLE = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic start,        // start edge detected this cycle (edge 0)
    input  logic active,       // frame in progress
    input  logic rx_in,
    output logic sampled_bit,  // bit decision, valid from the decision edge
    output logic bit_ready,    // decision edge OVERSAMPLE/2+2
    output logic bit_last,     // edge OVERSAMPLE-2, one cycle before bit end
    output logic bit_end       // edge OVERSAMPLE-1
);

    localparam int CW = $clog2(OVERSAMPLE);

    localparam logic [CW-1:0] C_EDGE_MID  = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] C_EDGE_DEC  = CW'(OVERSAMPLE / 2 + 2);
    localparam logic [CW-1:0] C_EDGE_LAST = CW'(OVERSAMPLE - 2);
    localparam logic [CW-1:0] C_EDGE_END  = CW'(OVERSAMPLE - 1);

    logic [CW-1:0] r_cnt;
    logic          r_mid;

    // Edge counter: the detect cycle is edge 0, so the next cycle is edge 1
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (start) begin
            r_cnt <= CW'(1);
        end else if (!active || r_cnt == C_EDGE_END) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Centre sample capture
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_mid <= 1'b1;
        end else if (active && r_cnt == C_EDGE_MID) begin
            r_mid <= rx_in;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    localparam logic [CW-1:0] C_EDGE_LO = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] C_EDGE_HI = CW'(OVERSAMPLE / 2 + 1);

    logic r_lo;
    logic r_hi;

    // Flanking sample capture for the majority vote
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_lo <= 1'b1;
            r_hi <= 1'b1;
        end else if (active) begin
            if (r_cnt == C_EDGE_LO) r_lo <= rx_in;
            if (r_cnt == C_EDGE_HI) r_hi <= rx_in;
        end
    end

    assign sampled_bit = (r_lo & r_mid) | (r_lo & r_hi) | (r_mid & r_hi);
`else
    assign sampled_bit = r_mid;
`endif

    assign bit_ready = active && (r_cnt == C_EDGE_DEC);
    assign bit_last  = active && (r_cnt == C_EDGE_LAST);
    assign bit_end   = active && (r_cnt == C_EDGE_END);

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
//  Module      : uart_rx
//  Description : Oversampling UART receiver. Qualifies the start bit,
//                shifts in DATA_WIDTH bits LSB first, optionally checks
//                even/odd parity, checks the stop bit and reports the
//                outcome with mutually exclusive one-cycle strobes.
//                Macro UART_RX_MAJORITY_EN enables 3-sample majority voting
//                in the bit sampler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR,
    output logic                  BUSY
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] C_BIT_LAST = BW'(DATA_WIDTH - 1);

    uart_state_t r_state;
    uart_state_t w_next;

    logic                  w_detect;
    logic                  w_active;
    logic                  w_sampled_bit;
    logic                  w_bit_ready;
    logic                  w_bit_last;
    logic                  w_bit_end;

    logic [BW-1:0]         r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_p_data;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_par_bad;
    logic                  r_valid;
    logic                  r_par_err;
    logic                  r_stp_err;

    assign w_detect = (r_state == IDLE) && !RX_IN;
    assign w_active = (r_state != IDLE);

    uart_rx_sampler #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_sampler (
        .CLK         (CLK),
        .RST         (RST),
        .start       (w_detect),
        .active      (w_active),
        .rx_in       (RX_IN),
        .sampled_bit (w_sampled_bit),
        .bit_ready   (w_bit_ready),
        .bit_last    (w_bit_last),
        .bit_end     (w_bit_end)
    );

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (!RX_IN) w_next = START;
            end
            START: begin
                // A start bit that samples high is a glitch
                if (w_bit_ready && w_sampled_bit) w_next = IDLE;
                else if (w_bit_end)               w_next = DATA;
            end
            DATA: begin
                if (w_bit_end && r_bit_cnt == C_BIT_LAST)
                    w_next = r_par_en ? PARITY : STOP;
            end
            PARITY: begin
                if (w_bit_end) w_next = STOP;
            end
            STOP: begin
                if (w_bit_end) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Frame datapath: latch config, shift data, check parity, issue strobes.
    // Strobes are decided one edge early so they are registered and still
    // land on the last cycle of the frame.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_p_data  <= '0;
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
            r_par_bad <= 1'b0;
            r_valid   <= 1'b0;
            r_par_err <= 1'b0;
            r_stp_err <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            r_par_err <= 1'b0;
            r_stp_err <= 1'b0;

            if (w_detect) begin
                r_par_en  <= PAR_EN;
                r_par_typ <= PAR_TYP;
                r_par_bad <= 1'b0;
                r_bit_cnt <= '0;
            end

            if (r_state == DATA) begin
                if (w_bit_ready) begin
                    r_shift <= {w_sampled_bit, r_shift[DATA_WIDTH-1:1]};
                end
                if (w_bit_end) begin
                    r_bit_cnt <= (r_bit_cnt == C_BIT_LAST) ? '0 : r_bit_cnt + 1'b1;
                end
            end

            if (r_state == PARITY && w_bit_ready) begin
                r_par_bad <= (w_sampled_bit != expected_parity(^r_shift, r_par_typ));
            end

            if (r_state == STOP && w_bit_last) begin
                if (!w_sampled_bit) begin
                    r_stp_err <= 1'b1;
                end else if (r_par_bad) begin
                    r_par_err <= 1'b1;
                end else begin
                    r_valid  <= 1'b1;
                    r_p_data <= r_shift;
                end
            end
        end
    end

    assign P_DATA     = r_p_data;
    assign DATA_VALID = r_valid;
    assign PAR_ERR    = r_par_err;
    assign STP_ERR    = r_stp_err;
    assign BUSY       = w_active;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Directed self-checking bench for uart_rx (DATA_WIDTH=8,
//                OVERSAMPLE=8). Cycle numbers are relative to the start
//                detect cycle of the marked frame.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_ERR;
    logic       STP_ERR;
    logic       BUSY;

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    int t0  = 0;

    // Strobe monitor state
    int         v_cnt, p_cnt, s_cnt, multi_cnt;
    int         v_cyc [4];
    logic [7:0] v_dat [4];
    int         p_cyc, s_cyc;
    int         busy_bad;
    logic [7:0] pd78;

    uart_rx #(
        .DATA_WIDTH (8),
        .OVERSAMPLE (8)
    ) u_dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc = cyc + 1;

    // Record strobes sampled mid-cycle
    always @(negedge CLK) begin
        if ((32'(DATA_VALID) + 32'(PAR_ERR) + 32'(STP_ERR)) > 1) multi_cnt = multi_cnt + 1;
        if (DATA_VALID) begin
            if (v_cnt < 4) begin
                v_cyc[v_cnt] = cyc - t0;
                v_dat[v_cnt] = P_DATA;
            end
            v_cnt = v_cnt + 1;
        end
        if (PAR_ERR) begin
            p_cyc = cyc - t0;
            p_cnt = p_cnt + 1;
        end
        if (STP_ERR) begin
            s_cyc = cyc - t0;
            s_cnt = s_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr_mon();
        v_cnt = 0; p_cnt = 0; s_cnt = 0;
        p_cyc = -1; s_cyc = -1;
        busy_bad = 0;
        for (int i = 0; i < 4; i++) begin
            v_cyc[i] = -1;
            v_dat[i] = 8'h00;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1 RX_IN = 1'b1;
        end
    endtask

    // Drive one frame, one value per cycle. flip inverts the centre sample
    // (edge 4) of that data bit; ncyc truncates the frame; mark sets t0.
    task automatic send_frame(input logic [7:0] d, input bit pen, input bit pbit,
                              input bit sbit, input int flip, input int ncyc,
                              input bit mark);
        int  nb;
        int  bi;
        int  sub;
        logic val;
        nb = pen ? 11 : 10;
        for (int c = 0; c < nb * 8 && c < ncyc; c++) begin
            bi  = c / 8;
            sub = c % 8;
            if (bi == 0)              val = 1'b0;
            else if (bi <= 8)         val = d[bi-1];
            else if (pen && bi == 9)  val = pbit;
            else                      val = sbit;
            if (bi >= 1 && bi <= 8 && flip == bi - 1 && sub == 4) val = ~val;
            @(posedge CLK);
            #1 RX_IN = val;
            if (mark && c == 0) t0 = cyc;
            @(negedge CLK);
            if (c == 78) pd78 = P_DATA;
            if (BUSY !== (c >= 1)) busy_bad = busy_bad + 1;
        end
    endtask

    logic b1, b7;
    logic [7:0] exp_flip;

    initial begin
        RST     = 1'b1;
        RX_IN   = 1'b1;
        PAR_EN  = 1'b0;
        PAR_TYP = 1'b0;
        multi_cnt = 0;
        pd78 = 8'h00;
        clr_mon();

        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_p_data", 32'(P_DATA), 32'h00);
        check("rst_valid",  32'(DATA_VALID), 0);
        check("rst_par_err", 32'(PAR_ERR), 0);
        check("rst_stp_err", 32'(STP_ERR), 0);
        check("rst_busy",   32'(BUSY), 0);
        @(posedge CLK);
        #1 RST = 1'b0;
        idle(4);

        // 8N1 0xA5
        clr_mon();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1, 1000, 1'b1);
        idle(3);
        check("8n1_valid_cnt", 32'(v_cnt), 1);
        check("8n1_valid_cyc", 32'(v_cyc[0]), 79);
        check("8n1_data", 32'(v_dat[0]), 32'hA5);
        check("8n1_err_cnt", 32'(p_cnt + s_cnt), 0);
        check("8n1_busy_window", 32'(busy_bad), 0);
        check("8n1_busy_after", 32'(BUSY), 0);

        // 8E1 0xA5, correct parity 0 then wrong parity 1
        PAR_EN = 1'b1; PAR_TYP = 1'b0;
        clr_mon();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, -1, 1000, 1'b1);
        idle(3);
        check("8e1_valid_cyc", 32'(v_cyc[0]), 87);
        check("8e1_data", 32'(v_dat[0]), 32'hA5);
        check("8e1_perr_cnt", 32'(p_cnt), 0);
        clr_mon();
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1, -1, 1000, 1'b1);
        idle(3);
        check("8e1_perr_cyc", 32'(p_cyc), 87);
        check("8e1_bad_valid_cnt", 32'(v_cnt), 0);
        check("8e1_bad_p_data", 32'(P_DATA), 32'hA5);

        // 8O1 0x3C, good parity (1), stop bit 0
        PAR_TYP = 1'b1;
        clr_mon();
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0, -1, 1000, 1'b1);
        idle(3);
        check("8o1_serr_cyc", 32'(s_cyc), 87);
        check("8o1_serr_cnt", 32'(s_cnt), 1);
        check("8o1_valid_perr_cnt", 32'(v_cnt + p_cnt), 0);
        // Bad parity and bad stop together: stop error only
        clr_mon();
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, -1, 1000, 1'b1);
        idle(3);
        check("both_err_serr_cnt", 32'(s_cnt), 1);
        check("both_err_perr_cnt", 32'(p_cnt + v_cnt), 0);
        check("both_err_p_data", 32'(P_DATA), 32'hA5);
        PAR_EN = 1'b0; PAR_TYP = 1'b0;

        // Start glitch: low for two cycles
        clr_mon();
        b1 = 1'b0; b7 = 1'b1;
        @(posedge CLK);
        #1 RX_IN = 1'b0;
        t0 = cyc;
        @(posedge CLK);
        #1 RX_IN = 1'b0;
        @(negedge CLK);
        b1 = BUSY;
        for (int c = 2; c <= 20; c++) begin
            @(posedge CLK);
            #1 RX_IN = 1'b1;
            @(negedge CLK);
            if (c == 7) b7 = BUSY;
        end
        check("glitch_busy_c1", 32'(b1), 1);
        check("glitch_busy_c7", 32'(b7), 0);
        check("glitch_strobes", 32'(v_cnt + p_cnt + s_cnt), 0);

        // Back-to-back 8N1: 0x55 then 0xFF, no idle gap
        clr_mon();
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, -1, 1000, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, -1, 1000, 1'b0);
        idle(3);
        check("b2b_valid_cnt", 32'(v_cnt), 2);
        check("b2b_cyc0", 32'(v_cyc[0]), 79);
        check("b2b_data0", 32'(v_dat[0]), 32'h55);
        check("b2b_cyc1", 32'(v_cyc[1]), 159);
        check("b2b_data1", 32'(v_dat[1]), 32'hFF);
        check("b2b_busy", 32'(busy_bad), 0);

        // Reset during DATA of 0x81, then 0x12
        clr_mon();
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, -1, 30, 1'b1);
        @(posedge CLK);
        #1 begin RST = 1'b1; RX_IN = 1'b1; end
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check("mid_rst_outputs",
              {19'd0, P_DATA, DATA_VALID, PAR_ERR, STP_ERR, BUSY, 1'b0}, 32'h0);
        idle(3);
        check("mid_rst_strobes", 32'(v_cnt + p_cnt + s_cnt), 0);
        clr_mon();
        pd78 = 8'hEE;
        send_frame(8'h12, 1'b0, 1'b0, 1'b1, -1, 1000, 1'b1);
        idle(3);
        check("post_rst_p_data_c78", 32'(pd78), 32'h00);
        check("post_rst_valid_cyc", 32'(v_cyc[0]), 79);
        check("post_rst_data", 32'(v_dat[0]), 32'h12);

        // Centre-sample disturbance on data bit 2 of 0xA5
`ifdef UART_RX_MAJORITY_EN
        exp_flip = 8'hA5;
`else
        exp_flip = 8'hA1;
`endif
        clr_mon();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 2, 1000, 1'b1);
        idle(3);
        check("flip_valid_cnt", 32'(v_cnt), 1);
        check("flip_data", 32'(v_dat[0]), 32'(exp_flip));

        check("strobe_exclusive", 32'(multi_cnt), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
